// File: rtl/sb_packet_framer_if.sv
// Sideband framer bus: header/data inputs from the encoders, frame output to the serializer.
// master drives the encoder-side inputs and observes the framer outputs; slave is the framer.
interface sb_packet_framer_if;
  logic [63:0] i_header;
  logic        i_hdr_valid;
  logic        i_has_data;
  logic [63:0] i_data_encoded;
  logic        i_d_valid;
  logic        i_ser_ready;
  logic [63:0] o_frame;
  logic        o_frame_valid;
  logic        o_busy;
  logic        o_overflow;

  modport master (
    output i_header, i_hdr_valid, i_has_data, i_data_encoded, i_d_valid, i_ser_ready,
    input  o_frame, o_frame_valid, o_busy, o_overflow
  );

  modport slave (
    input  i_header, i_hdr_valid, i_has_data, i_data_encoded, i_d_valid, i_ser_ready,
    output o_frame, o_frame_valid, o_busy, o_overflow
  );
endinterface

// File: rtl/sb_packet_framer.sv
// Sideband packet framer: captures a header (plus optional data word), patches the CP/DP
// parity bits and emits header then data to the serializer, followed by a fixed idle gap.
module sb_packet_framer #(
  parameter int unsigned GAP_CYCLES = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  sb_packet_framer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SEND_HDR,
    SEND_DATA,
    GAP
  } state_e;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [63:0] hdr_q, hdr_d;
  logic [63:0] data_q, data_d;
  logic        has_data_q, has_data_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        pad_window_q, pad_window_d;
  logic [63:0] frame_q, frame_d;
  logic        frame_valid_q, frame_valid_d;
  logic        overflow_q, overflow_d;
  logic        d_drop;

  // Bit 62 covers the header payload, bit 63 covers the data word (0 when there is none).
  function automatic logic [63:0] adjust_hdr(input logic [63:0] h, input logic [63:0] d,
                                             input logic hd);
    return {hd & (^d), ^h[61:0], h[61:0]};
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      hdr_q         <= '0;
      data_q        <= '0;
      has_data_q    <= 1'b0;
      gap_cnt_q     <= '0;
      pad_window_q  <= 1'b0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      data_q        <= data_d;
      has_data_q    <= has_data_d;
      gap_cnt_q     <= gap_cnt_d;
      pad_window_q  <= pad_window_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    data_d       = data_q;
    has_data_d   = has_data_q;
    gap_cnt_d    = gap_cnt_q;
    pad_window_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_hdr_valid) begin
          hdr_d        = bus.i_header;
          has_data_d   = bus.i_has_data;
          pad_window_d = !bus.i_has_data;
          if (!bus.i_has_data) begin
            data_d  = '0;
            state_d = SEND_HDR;
          end else if (bus.i_d_valid) begin
            data_d  = bus.i_data_encoded;
            state_d = SEND_HDR;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (bus.i_d_valid) begin
          data_d  = bus.i_data_encoded;
          state_d = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (bus.i_ser_ready) begin
          if (has_data_q) begin
            state_d = SEND_DATA;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      SEND_DATA: begin
        if (bus.i_ser_ready) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output word is decided from the next state so the frame appears one cycle after capture.
    frame_d       = '0;
    frame_valid_d = 1'b0;
    if (state_d == SEND_HDR) begin
      frame_d       = adjust_hdr(hdr_d, data_d, has_data_d);
      frame_valid_d = 1'b1;
    end else if (state_d == SEND_DATA) begin
      frame_d       = data_d;
      frame_valid_d = 1'b1;
    end

    // The zero-pad word of a data-less packet may trail the header by one cycle.
    d_drop = bus.i_d_valid && !pad_window_q &&
             ((state_q == SEND_HDR) || (state_q == SEND_DATA) || (state_q == GAP) ||
              ((state_q == IDLE) && !bus.i_hdr_valid));
    overflow_d = (bus.i_hdr_valid && (state_q != IDLE)) || d_drop;
  end

  assign bus.o_frame       = frame_q;
  assign bus.o_frame_valid = frame_valid_q;
  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_overflow    = overflow_q;

endmodule

// File: tb/tb_sb_packet_framer.sv
// Directed bench for sb_packet_framer: hand-computed frames, gap length, overflow and reset.
module tb_sb_packet_framer;

  logic i_clk;
  logic i_rst_n;
  int   n_checks;
  int   n_pass;

  sb_packet_framer_if bus_if ();

  sb_packet_framer #(.GAP_CYCLES(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus_if)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.i_header       = '0;
    bus_if.i_hdr_valid    = 1'b0;
    bus_if.i_has_data     = 1'b0;
    bus_if.i_data_encoded = '0;
    bus_if.i_d_valid      = 1'b0;
  endtask

  task automatic send_hdr(input logic [63:0] h, input logic hd, input logic dv,
                          input logic [63:0] d);
    bus_if.i_header       = h;
    bus_if.i_hdr_valid    = 1'b1;
    bus_if.i_has_data     = hd;
    bus_if.i_d_valid      = dv;
    bus_if.i_data_encoded = d;
    step();
    idle_inputs();
  endtask

  // Counts clock steps until the framer returns to IDLE, bounded so a stuck FSM still fails.
  task automatic wait_idle(input string tag, input int exp_steps);
    int n;
    n = 0;
    while (bus_if.o_busy && n < 32) begin
      step();
      n++;
    end
    check(tag, 64'(n), 64'(exp_steps));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    i_rst_n  = 1'b0;
    idle_inputs();
    bus_if.i_ser_ready = 1'b1;
    step();
    step();
    check("rst_frame", bus_if.o_frame, 64'h0);
    check("rst_valid", 64'(bus_if.o_frame_valid), 64'h0);
    check("rst_busy", 64'(bus_if.o_busy), 64'h0);
    check("rst_ovf", 64'(bus_if.o_overflow), 64'h0);
    i_rst_n = 1'b1;

    // Header only, accepted on the first edge after reset release; pad word one cycle later.
    send_hdr(64'h0000_0000_0000_0001, 1'b0, 1'b0, 64'h0);
    check("s1_hdr", bus_if.o_frame, 64'h4000_0000_0000_0001);
    check("s1_hdr_valid", 64'(bus_if.o_frame_valid), 64'h1);
    bus_if.i_d_valid = 1'b1;
    step();
    bus_if.i_d_valid = 1'b0;
    check("s1_pad_no_ovf", 64'(bus_if.o_overflow), 64'h0);
    check("s1_gap_valid", 64'(bus_if.o_frame_valid), 64'h0);
    check("s1_gap_frame", bus_if.o_frame, 64'h0);
    check("s1_gap_busy", 64'(bus_if.o_busy), 64'h1);
    wait_idle("s1_gap_len", 4);
    $display("packet s1 header-only done at %0t", $time);

    // Header with same-cycle data.
    send_hdr(64'h0, 1'b1, 1'b1, 64'h1);
    check("s2_hdr", bus_if.o_frame, 64'h8000_0000_0000_0000);
    step();
    check("s2_data", bus_if.o_frame, 64'h1);
    check("s2_data_valid", 64'(bus_if.o_frame_valid), 64'h1);
    step();
    check("s2_gap_valid", 64'(bus_if.o_frame_valid), 64'h0);
    wait_idle("s2_gap_len", 4);
    $display("packet s2 header+data done at %0t", $time);

    // Data arrives five cycles late; incoming CP/DP bits must be overwritten.
    send_hdr(64'hC123_4567_89AB_CDEF, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("s3_wait%0d_valid", i), 64'(bus_if.o_frame_valid), 64'h0);
      if (i == 4) begin
        check("s3_wait_busy", 64'(bus_if.o_busy), 64'h1);
        bus_if.i_d_valid      = 1'b1;
        bus_if.i_data_encoded = 64'hFEDC_BA98_7654_3211;
      end
      step();
    end
    idle_inputs();
    check("s3_hdr", bus_if.o_frame, 64'h8123_4567_89AB_CDEF);
    step();
    check("s3_data", bus_if.o_frame, 64'hFEDC_BA98_7654_3211);
    step();
    wait_idle("s3_gap_len", 4);
    $display("packet s3 late data done at %0t", $time);

    // Serializer back-pressure for three cycles in SEND_HDR.
    bus_if.i_ser_ready = 1'b0;
    send_hdr(64'h0000_0000_0000_0007, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s4_hold%0d", i), bus_if.o_frame, 64'h4000_0000_0000_0007);
      if (i == 3) bus_if.i_ser_ready = 1'b1;
      step();
    end
    check("s4_after_valid", 64'(bus_if.o_frame_valid), 64'h0);
    wait_idle("s4_gap_len", 4);
    $display("packet s4 backpressure done at %0t", $time);

    // Second header during SEND_DATA is dropped; stray data in GAP and IDLE also overflow.
    send_hdr(64'h0000_0000_0000_0005, 1'b1, 1'b1, 64'hB);
    check("s5_hdr", bus_if.o_frame, 64'h8000_0000_0000_0005);
    step();
    bus_if.i_ser_ready = 1'b0;
    bus_if.i_header    = 64'hFFFF;
    bus_if.i_hdr_valid = 1'b1;
    step();
    idle_inputs();
    bus_if.i_ser_ready = 1'b1;
    check("s5_ovf_pulse", 64'(bus_if.o_overflow), 64'h1);
    check("s5_data_kept", bus_if.o_frame, 64'hB);
    step();
    check("s5_ovf_single", 64'(bus_if.o_overflow), 64'h0);
    check("s5_gap_valid", 64'(bus_if.o_frame_valid), 64'h0);
    bus_if.i_d_valid = 1'b1;
    step();
    bus_if.i_d_valid = 1'b0;
    check("s5_gap_dvalid_ovf", 64'(bus_if.o_overflow), 64'h1);
    wait_idle("s5_gap_len", 3);
    bus_if.i_d_valid = 1'b1;
    step();
    bus_if.i_d_valid = 1'b0;
    check("s5_idle_dvalid_ovf", 64'(bus_if.o_overflow), 64'h1);
    check("s5_idle_busy", 64'(bus_if.o_busy), 64'h0);
    step();
    check("s5_idle_ovf_clear", 64'(bus_if.o_overflow), 64'h0);
    $display("packet s5 overflow done at %0t", $time);

    // Reset asserted mid SEND_DATA clears outputs immediately; next header frames normally.
    send_hdr(64'h0000_0000_0000_0001, 1'b1, 1'b1, 64'h2);
    step();
    check("s6_data", bus_if.o_frame, 64'h2);
    i_rst_n = 1'b0;
    #1;
    check("s6_rst_frame", bus_if.o_frame, 64'h0);
    check("s6_rst_valid", 64'(bus_if.o_frame_valid), 64'h0);
    check("s6_rst_busy", 64'(bus_if.o_busy), 64'h0);
    step();
    i_rst_n = 1'b1;
    step();
    check("s6_post_rst_valid", 64'(bus_if.o_frame_valid), 64'h0);
    send_hdr(64'h0000_0000_0000_0003, 1'b0, 1'b0, 64'h0);
    check("s6_new_hdr", bus_if.o_frame, 64'h3);
    check("s6_new_valid", 64'(bus_if.o_frame_valid), 64'h1);
    step();
    wait_idle("s6_gap_len", 4);
    $display("packet s6 reset recovery done at %0t", $time);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
